// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: iterative binary-to-BCD converter (shift-add-3, one bit per cycle)
// with valid/ready handshakes, overflow detection and optional leading-zero blanking.
module bcd_seq_conv #(
  parameter int unsigned N        = 32,
  parameter int unsigned DIGITS   = 10,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          bin,
  input  logic                  i_vld,
  output logic                  i_rdy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf,
  output logic                  o_vld,
  input  logic                  o_rdy
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] RST_BLANK = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              r_state;
  logic [N-1:0]        r_shreg;
  logic [BW-1:0]       r_work;
  logic                r_wovf;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bcd;
  logic [DIGITS-1:0]   r_blank;
  logic                r_ovf;
  logic                r_ovld;

  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_work_nxt;
  logic                w_ovf_nxt;
  logic [DIGITS-1:0]   w_blank;
  logic                w_zero;

  // Add-3 correction on every digit >= 5, then one-bit shift of {work, shreg}
  always_comb begin
    w_adj = r_work;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
      end
    end
    w_work_nxt = {w_adj[BW-2:0], r_shreg[N-1]};
    w_ovf_nxt  = r_wovf | w_adj[BW-1];
  end

  // Leading-zero mask from the final working value; digit 0 is never blanked
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      w_zero     = w_zero & (w_work_nxt[4*k +: 4] == 4'd0);
      w_blank[k] = w_zero;
    end
    if ((BLANK_LZ == 0) || w_ovf_nxt) begin
      w_blank = '0;
    end
  end

  // Control FSM and datapath; results are captured on the final shift so they
  // appear together with o_vld on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_work  <= '0;
      r_wovf  <= 1'b0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_blank <= RST_BLANK;
      r_ovf   <= 1'b0;
      r_ovld  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_vld) begin
            r_shreg <= bin;
            r_work  <= '0;
            r_wovf  <= 1'b0;
            r_cnt   <= CW'(N);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg <= r_shreg << 1;
          r_work  <= w_work_nxt;
          r_wovf  <= w_ovf_nxt;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd   <= w_work_nxt;
            r_ovf   <= w_ovf_nxt;
            r_blank <= w_blank;
            r_ovld  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (o_rdy) begin
            r_ovld  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_rdy = (r_state == IDLE);
  assign bcd   = r_bcd;
  assign blank = r_blank;
  assign ovf   = r_ovf;
  assign o_vld = r_ovld;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench for bcd_seq_conv: four instances covering the default,
// overflow-prone, and both blanking configurations.
module tb_bcd_seq_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: N=32, DIGITS=10, BLANK_LZ=1
  logic [31:0] a_bin = '0;
  logic        a_ivld = 1'b0, a_ordy = 1'b1;
  logic        a_irdy, a_ovld, a_ovf;
  logic [39:0] a_bcd;
  logic [9:0]  a_blank;
  // Instance B: N=16, DIGITS=3, BLANK_LZ=1
  logic [15:0] b_bin = '0;
  logic        b_ivld = 1'b0, b_ordy = 1'b1;
  logic        b_irdy, b_ovld, b_ovf;
  logic [11:0] b_bcd;
  logic [2:0]  b_blank;
  // Instances C (BLANK_LZ=1) and D (BLANK_LZ=0): N=16, DIGITS=4, shared inputs
  logic [15:0] cd_bin = '0;
  logic        cd_ivld = 1'b0, cd_ordy = 1'b1;
  logic        c_irdy, c_ovld, c_ovf, d_irdy, d_ovld, d_ovf;
  logic [15:0] c_bcd, d_bcd;
  logic [3:0]  c_blank, d_blank;

  bcd_seq_conv #(.N(32), .DIGITS(10), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .bin(a_bin), .i_vld(a_ivld), .i_rdy(a_irdy),
    .bcd(a_bcd), .blank(a_blank), .ovf(a_ovf), .o_vld(a_ovld), .o_rdy(a_ordy));
  bcd_seq_conv #(.N(16), .DIGITS(3), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst(rst), .bin(b_bin), .i_vld(b_ivld), .i_rdy(b_irdy),
    .bcd(b_bcd), .blank(b_blank), .ovf(b_ovf), .o_vld(b_ovld), .o_rdy(b_ordy));
  bcd_seq_conv #(.N(16), .DIGITS(4), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .bin(cd_bin), .i_vld(cd_ivld), .i_rdy(c_irdy),
    .bcd(c_bcd), .blank(c_blank), .ovf(c_ovf), .o_vld(c_ovld), .o_rdy(cd_ordy));
  bcd_seq_conv #(.N(16), .DIGITS(4), .BLANK_LZ(0)) u_d (
    .clk(clk), .rst(rst), .bin(cd_bin), .i_vld(cd_ivld), .i_rdy(d_irdy),
    .bcd(d_bcd), .blank(d_blank), .ovf(d_ovf), .o_vld(d_ovld), .o_rdy(cd_ordy));

  typedef struct {
    logic [39:0] bcd;
    logic [9:0]  blank;
    logic        ovf;
    int          rise;
  } exp_t;

  exp_t qa[$], qb[$], qc[$], qd[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cmp_out(input string nm, input logic [39:0] b, input logic [9:0] bl,
                         input logic o, input int rise, input exp_t e);
    chk({nm, "_bcd"},   64'(b),    64'(e.bcd));
    chk({nm, "_blank"}, 64'(bl),   64'(e.blank));
    chk({nm, "_ovf"},   64'(o),    64'(e.ovf));
    chk({nm, "_lat"},   64'(rise), 64'(e.rise));
  endtask

  task automatic no_exp(input string nm);
    n_total++;
    $display("FAIL %s_unexpected: got o_vld=1 expected no pending result", nm);
  endtask

  // Monitors: note the cycle o_vld rises, pop and compare on each output handshake
  logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0, d_prev = 1'b0;
  int   a_rise = 0, b_rise = 0, c_rise = 0, d_rise = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (a_ovld === 1'b1 && a_prev !== 1'b1) a_rise = cyc;
      if (a_ovld === 1'b1 && a_ordy) begin
        if (qa.size() == 0) no_exp("A");
        else begin e = qa.pop_front(); cmp_out("A", a_bcd, a_blank, a_ovf, a_rise, e); end
      end
    end
    a_prev = a_ovld;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (b_ovld === 1'b1 && b_prev !== 1'b1) b_rise = cyc;
      if (b_ovld === 1'b1 && b_ordy) begin
        if (qb.size() == 0) no_exp("B");
        else begin e = qb.pop_front(); cmp_out("B", 40'(b_bcd), 10'(b_blank), b_ovf, b_rise, e); end
      end
    end
    b_prev = b_ovld;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (c_ovld === 1'b1 && c_prev !== 1'b1) c_rise = cyc;
      if (c_ovld === 1'b1 && cd_ordy) begin
        if (qc.size() == 0) no_exp("C");
        else begin e = qc.pop_front(); cmp_out("C", 40'(c_bcd), 10'(c_blank), c_ovf, c_rise, e); end
      end
    end
    c_prev = c_ovld;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (d_ovld === 1'b1 && d_prev !== 1'b1) d_rise = cyc;
      if (d_ovld === 1'b1 && cd_ordy) begin
        if (qd.size() == 0) no_exp("D");
        else begin e = qd.pop_front(); cmp_out("D", 40'(d_bcd), 10'(d_blank), d_ovf, d_rise, e); end
      end
    end
    d_prev = d_ovld;
  end

  function automatic bit rdy(input int id);
    case (id)
      0:       return a_irdy === 1'b1;
      1:       return b_irdy === 1'b1;
      default: return (c_irdy === 1'b1) && (d_irdy === 1'b1);
    endcase
  endfunction

  // Issue one input handshake; optionally push the hand-computed result.
  // t is the cycle in which i_vld&i_rdy were high; o_vld is due at t+N+1.
  task automatic send(input int id, input logic [31:0] v, input logic [39:0] eb,
                      input logic [9:0] ebl, input logic [9:0] ebl2, input logic eo,
                      input bit push, output int t);
    int   n = 0;
    exp_t e;
    while (!rdy(id) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL send%0d_timeout: i_rdy low for %0d cycles, expected high", id, n);
    end
    t = cyc;
    case (id)
      0:       begin a_bin = v; a_ivld = 1'b1; end
      1:       begin b_bin = v[15:0]; b_ivld = 1'b1; end
      default: begin cd_bin = v[15:0]; cd_ivld = 1'b1; end
    endcase
    @(posedge clk); #1;
    a_ivld = 1'b0; b_ivld = 1'b0; cd_ivld = 1'b0;
    if (push) begin
      e.bcd = eb; e.blank = ebl; e.ovf = eo;
      e.rise = t + ((id == 0) ? 32 : 16) + 1;
      case (id)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: begin qc.push_back(e); e.blank = ebl2; qd.push_back(e); end
      endcase
    end
  endtask

  initial begin
    int t1, t2, t3, t4, n, bad, bad_rdy;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_irdy",  64'(a_irdy),  64'(1));
    chk("rst_ovld",  64'(a_ovld),  64'(0));
    chk("rst_bcd",   64'(a_bcd),   64'(0));
    chk("rst_ovf",   64'(a_ovf),   64'(0));
    chk("rst_blankA", 64'(a_blank), 64'(10'b1111111110));
    chk("rst_blankB", 64'(b_blank), 64'(3'b110));
    chk("rst_blankD", 64'(d_blank), 64'(0));

    // Instance A: N=32, DIGITS=10
    send(0, 32'd0,          40'h0000000000, 10'b1111111110, '0, 1'b0, 1'b1, t1);
    send(0, 32'hFFFFFFFF,   40'h4294967295, 10'b0000000000, '0, 1'b0, 1'b1, t1);
    send(0, 32'd1234567890, 40'h1234567890, 10'b0000000000, '0, 1'b0, 1'b1, t1);
    send(0, 32'd1000000,    40'h0001000000, 10'b1110000000, '0, 1'b0, 1'b1, t1);

    // Instance B: N=16, DIGITS=3, overflow boundary
    send(1, 32'd999,   40'h999, 10'b000, '0, 1'b0, 1'b1, t1);
    send(1, 32'd1000,  40'h000, 10'b000, '0, 1'b1, 1'b1, t1);
    send(1, 32'd1234,  40'h234, 10'b000, '0, 1'b1, 1'b1, t1);
    send(1, 32'd7,     40'h007, 10'b110, '0, 1'b0, 1'b1, t1);
    send(1, 32'd65535, 40'h535, 10'b000, '0, 1'b1, 1'b1, t1);

    // Backpressure on A with an ignored i_vld pulse
    a_ordy = 1'b0;
    send(0, 32'hFFFFFFFF, 40'h4294967295, 10'b0, '0, 1'b0, 1'b1, t1);
    n = 0;
    while (a_ovld !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_ovld_seen", 64'(a_ovld), 64'(1));
    bad = 0; bad_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_ovld !== 1'b1 || a_bcd !== 40'h4294967295 || a_blank !== 10'b0 || a_ovf !== 1'b0) bad++;
      if (a_irdy !== 1'b0) bad_rdy++;
      if (i == 5) begin a_bin = 32'd7; a_ivld = 1'b1; end
      else a_ivld = 1'b0;
      @(posedge clk); #1;
    end
    a_ivld = 1'b0;
    chk("bp_stable_cycles_bad", 64'(bad), 64'(0));
    chk("bp_irdy_cycles_bad", 64'(bad_rdy), 64'(0));
    a_ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ovld", 64'(a_ovld), 64'(0));
    chk("bp_release_irdy", 64'(a_irdy), 64'(1));
    chk("bp_bcd_held",     64'(a_bcd),  64'(40'h4294967295));

    // Reset five cycles into a conversion
    send(0, 32'd99, '0, '0, '0, 1'b0, 1'b0, t1);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ovld", 64'(a_ovld), 64'(0));
    chk("midrst_irdy", 64'(a_irdy), 64'(1));
    chk("midrst_bcd",  64'(a_bcd),  64'(0));
    chk("midrst_ovf",  64'(a_ovf),  64'(0));
    rst = 1'b0;
    send(0, 32'd42, 40'h0000000042, 10'b1111111100, '0, 1'b0, 1'b1, t1);

    // C/D: blanking on/off, back-to-back initiation interval N+2
    send(2, 32'd42,    40'h0042, 10'b1100, 10'b0000, 1'b0, 1'b1, t1);
    send(2, 32'd9999,  40'h9999, 10'b0000, 10'b0000, 1'b0, 1'b1, t2);
    chk("cd_ii_1", 64'(t2 - t1), 64'(18));
    send(2, 32'd10000, 40'h0000, 10'b0000, 10'b0000, 1'b1, 1'b1, t3);
    chk("cd_ii_2", 64'(t3 - t2), 64'(18));
    send(2, 32'd5,     40'h0005, 10'b1110, 10'b0000, 1'b0, 1'b1, t4);
    chk("cd_ii_3", 64'(t4 - t3), 64'(18));

    // Drain scoreboards
    n = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(qa.size() + qb.size() + qc.size() + qd.size()), 64'(0));
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_seq_conv.md
Name: bcd_seq_conv

Overview:
Parametrised sequential binary-to-BCD converter with valid/ready handshakes on both sides. It replaces the wide combinational double-dabble in the display data path with an N-cycle iterative shift-add-3 engine. It adds overflow detection and optional leading-zero blanking. It sits between the value source (counter or sensor register) and the seven-segment decode/serializer chain.

Parameters:
N, 32, binary input width (>=1)
DIGITS, 10, number of BCD output digits (>=1); output width 4*DIGITS
BLANK_LZ, 1, 1 = generate leading-zero blank mask; 0 = blank mask forced to all zeros

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
bin  input  N  binary value; sampled only on input handshake
i_vld  input  1  input valid
i_rdy  output  1  input ready; high only in IDLE
bcd  output  4*DIGITS  registered result; digit k at bits [4k+3:4k], digit 0 = ones
blank  output  DIGITS  registered per-digit blank flag (1 = display dark)
ovf  output  1  registered; result did not fit in DIGITS digits
o_vld  output  1  result valid
o_rdy  input  1  downstream ready

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, o_vld=0, bcd=0, ovf=0. blank = all ones except bit 0 when BLANK_LZ=1, and 0 when BLANK_LZ=0. i_rdy=1 from the first cycle after reset. A reset mid-conversion aborts it with no o_vld pulse.
- FSM states:
  - IDLE: i_rdy=1. On i_vld&i_rdy at cycle t: latch bin into the shift register, clear the working BCD register and the overflow flag, load bit counter = N, go to SHIFT.
  - SHIFT: one bit per cycle. First, add 3 to every working digit >=5. Then shift {work, shreg} left by 1; the shreg MSB enters digit-0 LSB. A 1 shifted out of the top digit's MSB sets the working overflow flag (sticky for this conversion). Decrement the counter. After N cycles (t+1..t+N), go to DONE.
  - DONE: entered at t+N+1. On entry, copy the working register to bcd, copy the flag to ovf, compute blank, and set o_vld=1. Hold all outputs stable while o_vld&!o_rdy. On o_vld&o_rdy at cycle u: o_vld=0 at u+1, state IDLE at u+1, i_rdy=1 at u+1.
- Latency: o_vld asserts exactly N+1 cycles after the accepting edge. Minimum initiation interval: N+2 cycles.
- bcd, blank and ovf keep their last values after the handshake until the next DONE entry.
- Overflow: if bin >= 10^DIGITS, then ovf=1 and bcd = bin mod 10^DIGITS (lower digits remain exact). Otherwise ovf=0.
- Blank (BLANK_LZ=1): blank[k]=1 iff digit k and all higher digits are zero, for k>=1. blank[0] is always 0, so value 0 shows "0". When ovf=1, blank is all zeros.
- i_vld while not in IDLE is ignored; no queuing.
- Arithmetic: digits never exceed 9 after correction. The counter is width $clog2(N+1).

Test Plan:
1. N=32, DIGITS=10: accept bin=0 at cycle t -> o_vld at t+33, bcd=0, blank=10'b1111111110, ovf=0.
2. bin=32'hFFFFFFFF -> bcd digits 4,2,9,4,9,6,7,2,9,5 (MSD..LSD), blank=0, ovf=0.
3. N=16, DIGITS=3: bin=999 -> bcd=12'h999, ovf=0. bin=1000 -> bcd=12'h000, ovf=1, blank=0. bin=1234 -> bcd=12'h234, ovf=1.
4. Backpressure: hold o_rdy=0 for 20 cycles after o_vld -> bcd/blank/ovf/o_vld stable, i_rdy=0, a pulsed i_vld ignored. Then o_rdy=1 for one cycle -> o_vld=0 and i_rdy=1 next cycle.
5. Reset mid-SHIFT (5 cycles after accept) -> next cycle o_vld=0, i_rdy=1, bcd=0, ovf=0. A new conversion of 42 then completes normally with bcd=...042.
6. bin=42, DIGITS=4: BLANK_LZ=1 -> blank=4'b1100. BLANK_LZ=0 -> blank=4'b0000. Back-to-back inputs with o_rdy=1 -> results spaced exactly N+2 cycles apart.
